ntp_time_sync: RTL and testbench
================================

# ntp_time_sync

Upstream time source for `ntp_clock`. Accepts a 32-bit NTP seconds value from the HPS bridge over a valid/ready handshake, arms it, and applies it on the next PPS edge from the GPIO detector. From then on it free-runs a seconds counter at 1 Hz, disciplined by PPS. `time_out` drives the `HPS_CLOCK` input of `ntp_clock`.

## Interface
- `CLK_HZ`, 50_000_000: clk frequency; one second equals CLK_HZ cycles.
- `PPS_TIMEOUT`, 2: seconds without a PPS edge before arming times out or lock is dropped.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `pps_in` in 1: asynchronous PPS pulse from GPIO, at least 2 clk cycles wide.
- `set_valid` in 1: HPS offers `set_seconds`.
- `set_seconds` in 32: NTP seconds to load.
- `set_ready` out 1: block can accept a set.
- `time_out` out 32: current seconds, to `ntp_clock` `HPS_CLOCK`.
- `time_valid` out 1: `time_out` has been loaded at least once since reset.
- `tick_1hz` out 1: one-cycle pulse each time `time_out` changes.
- `pps_locked` out 1: PPS is present and disciplining the counter.

## Operation
- **PPS synchroniser:** 2-flop synchroniser plus one history flop. The edge pulse `pps_rise` is `s2 & ~s3`.
- **`subsec` counter:** 0..CLK_HZ-1.
- **`miss_cnt`:** counts seconds without a PPS edge and saturates at PPS_TIMEOUT.
- **States:** IDLE, ARMED, RUN. `set_ready` = (state != ARMED).
- **Handshake:** a transfer happens when `set_valid & set_ready` on a rising edge. `set_seconds` is latched into `pending`. `set_valid` may stay high; one transfer per acceptance.
- **IDLE:**
  - `subsec` is held at 0.
  - A transfer moves the block to ARMED.
- **ARMED:**
  - On `pps_rise`: `time_out` ← `pending`, `subsec` ← 0, `time_valid` ← 1, `pps_locked` ← 1, `miss_cnt` ← 0, pulse `tick_1hz`, go to RUN.
  - Timeout after PPS_TIMEOUT·CLK_HZ cycles in ARMED with no `pps_rise`: apply `pending` the same way, but `pps_locked` ← 0, then go to RUN.
  - If `time_valid` is already 1, the old time keeps counting in ARMED, following RUN rules, until the load.
- **RUN:**
  - **Rollover:** when `subsec` = CLK_HZ-1, `subsec` ← 0, `time_out` ← `time_out`+1, and `tick_1hz` pulses.
  - **PPS arriving early:** `pps_rise` with `subsec` ≥ CLK_HZ/2. `subsec` ← 0, `time_out`+1, `tick_1hz` pulses.
  - **PPS arriving late:** `pps_rise` with `subsec` < CLK_HZ/2. `subsec` ← 0 and there is no increment, because the second was already counted.
  - **Lock:** any `pps_rise` sets `pps_locked` and clears `miss_cnt`. Each rollover without a PPS in that second increments `miss_cnt`. When `miss_cnt` reaches PPS_TIMEOUT, `pps_locked` ← 0.
  - **New set:** a transfer in RUN moves the block to ARMED. The current time continues counting.
- **Arithmetic:** `time_out` wraps from 0xFFFFFFFF to 0x00000000 with no flag.
- **Simultaneous events:**
  - PPS edge and rollover in the same cycle: exactly one increment.
  - Transfer and `pps_rise` in the same RUN cycle: the PPS is processed against the current time, then ARMED. `pending` applies at the next edge, not this one.
- **Reset:**
  - Outputs: `time_out`=0, `time_valid`=0, `tick_1hz`=0, `pps_locked`=0.
  - Internal state: IDLE, `subsec`=0, `miss_cnt`=0, `pending`=0, synchroniser flops=0.
  - `set_ready` reads 1, but no transfer is taken while `reset` is high.
  - Reset mid-operation discards `pending` and all time.

## Timing
- `pps_in` first sampled high at edge N: `pps_rise` is asserted between N+1 and N+2, and `time_out`/`tick_1hz` update at edge N+2.
- **Handshake:** a transfer at edge T makes `set_ready` 0 from T (state ARMED) until the load edge. `set_ready` is 1 again in the cycle after the load.
- **Outputs:** `tick_1hz` is high for exactly one cycle, coincident with the new `time_out` value. All outputs are registered.
- **Free-run period:** exactly CLK_HZ cycles between `tick_1hz` pulses absent PPS.

## Structure
- **Package `ntp_pkg`:** `state_t` enum (IDLE, ARMED, RUN), `ntp_sec_t` (32-bit seconds typedef), and a `PPS_SYNC_STAGES`=2 constant. `ntp_clock` imports the same package.
- **Sub-module `pps_sync`:** synchroniser plus rising-edge detector, output `pps_rise`.
- **`ntp_time_sync`:** owns the FSM, counters and handshake.

## Test plan
All scenarios run with CLK_HZ=1000 and PPS_TIMEOUT=2.
- Reset, then set 0x6000_0000, then a PPS pulse → `time_out`=0x6000_0000 and `time_valid`=1 exactly 2 edges after `pps_in` is sampled. `pps_locked`=1, one `tick_1hz`.
- Set 5 with no PPS → load happens after 2000 cycles in ARMED, `pps_locked`=0. Then `tick_1hz` every 1000 cycles with `time_out` 6, 7, ….
- Locked at 100, PPS at `subsec`=990 → `time_out`=101 with no later double increment. PPS at `subsec`=10 → `subsec` realigned, `time_out` unchanged.
- Locked, then PPS stops → `pps_locked` drops at the 2nd rollover without PPS while counting continues. PPS resumes → relocks.
- Load 0xFFFF_FFFF, wait 1 s → `time_out`=0, `tick_1hz` pulses.
- `set_valid` held high through ARMED → only one transfer. Transfer coinciding with `pps_rise` in RUN → new value applied only at the following PPS. Reset asserted in ARMED → IDLE, all outputs 0.

Source files
------------

// File: rtl/ntp_pkg.sv
// rtl/ntp_pkg.sv - shared types and constants for the NTP time path
package ntp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef logic [31:0] ntp_sec_t;

    localparam int PPS_SYNC_STAGES = 2;

endpackage

// File: rtl/pps_sync.sv
// rtl/pps_sync.sv - PPS input synchroniser and rising-edge detector
module pps_sync
    import ntp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic pps_in,
    output logic pps_rise
);

    // Top bit is a history copy of the synchronised level, used for edge detection.
    logic [PPS_SYNC_STAGES:0] sync_q;
    logic [PPS_SYNC_STAGES:0] sync_d;

    always_comb begin
        sync_d = {sync_q[PPS_SYNC_STAGES-1:0], pps_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign pps_rise = sync_q[PPS_SYNC_STAGES-1] & ~sync_q[PPS_SYNC_STAGES];

endmodule

// File: rtl/ntp_time_sync.sv
// rtl/ntp_time_sync.sv - NTP seconds loader and PPS-disciplined 1 Hz counter
module ntp_time_sync
    import ntp_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int PPS_TIMEOUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pps_in,
    input  logic        set_valid,
    input  logic [31:0] set_seconds,
    output logic        set_ready,
    output logic [31:0] time_out,
    output logic        time_valid,
    output logic        tick_1hz,
    output logic        pps_locked
);

    localparam int SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int AW = (PPS_TIMEOUT * CLK_HZ > 1) ? $clog2(PPS_TIMEOUT * CLK_HZ) : 1;
    localparam int MW = $clog2(PPS_TIMEOUT + 1);
    localparam logic [SW-1:0] SUB_MAX  = SW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SUB_HALF = SW'(CLK_HZ / 2);
    localparam logic [AW-1:0] ARM_MAX  = AW'(PPS_TIMEOUT * CLK_HZ - 1);
    localparam logic [MW-1:0] MISS_MAX = MW'(PPS_TIMEOUT);

    logic pps_rise;

    pps_sync u_pps_sync (
        .clk      (clk),
        .reset    (reset),
        .pps_in   (pps_in),
        .pps_rise (pps_rise)
    );

    state_t   state_q, state_d;
    logic [SW-1:0] subsec_q, subsec_d;
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;
    logic [MW-1:0] miss_q, miss_d;
    ntp_sec_t pending_q, pending_d;
    ntp_sec_t time_q, time_d;
    logic valid_q, valid_d;
    logic tick_q, tick_d;
    logic locked_q, locked_d;
    logic ready_q, ready_d;

    logic xfer;
    logic rollover;
    logic early;

    assign xfer     = set_valid & ready_q;
    assign rollover = (subsec_q == SUB_MAX);
    assign early    = (subsec_q >= SUB_HALF);

    always_comb begin
        state_d   = state_q;
        subsec_d  = subsec_q;
        arm_cnt_d = arm_cnt_q;
        miss_d    = miss_q;
        pending_d = pending_q;
        time_d    = time_q;
        valid_d   = valid_q;
        tick_d    = 1'b0;
        locked_d  = locked_q;

        if (xfer) begin
            pending_d = set_seconds;
        end

        // Once time is valid it counts in both ARMED and RUN; a PPS that lands
        // in the second half of a second is treated as the next second's start.
        if (valid_q) begin
            if (pps_rise) begin
                subsec_d = '0;
                miss_d   = '0;
                locked_d = 1'b1;
                if (early) begin
                    time_d = time_q + 32'd1;
                    tick_d = 1'b1;
                end
            end else if (rollover) begin
                subsec_d = '0;
                time_d   = time_q + 32'd1;
                tick_d   = 1'b1;
                if (miss_q != MISS_MAX) begin
                    miss_d = miss_q + MW'(1);
                end
                if (miss_d == MISS_MAX) begin
                    locked_d = 1'b0;
                end
            end else begin
                subsec_d = subsec_q + SW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d   = ARMED;
                    arm_cnt_d = '0;
                end
            end
            ARMED: begin
                if (pps_rise || (arm_cnt_q == ARM_MAX)) begin
                    time_d   = pending_q;
                    subsec_d = '0;
                    valid_d  = 1'b1;
                    locked_d = pps_rise;
                    miss_d   = '0;
                    tick_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    arm_cnt_d = arm_cnt_q + AW'(1);
                end
            end
            RUN: begin
                if (xfer) begin
                    state_d   = ARMED;
                    arm_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != ARMED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            subsec_q  <= '0;
            arm_cnt_q <= '0;
            miss_q    <= '0;
            pending_q <= '0;
            time_q    <= '0;
            valid_q   <= 1'b0;
            tick_q    <= 1'b0;
            locked_q  <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            subsec_q  <= subsec_d;
            arm_cnt_q <= arm_cnt_d;
            miss_q    <= miss_d;
            pending_q <= pending_d;
            time_q    <= time_d;
            valid_q   <= valid_d;
            tick_q    <= tick_d;
            locked_q  <= locked_d;
            ready_q   <= ready_d;
        end
    end

    assign set_ready  = ready_q;
    assign time_out   = time_q;
    assign time_valid = valid_q;
    assign tick_1hz   = tick_q;
    assign pps_locked = locked_q;

endmodule

// File: tb/tb_ntp_time_sync.sv
// tb/tb_ntp_time_sync.sv - randomized and directed bench for ntp_time_sync
module tb_ntp_time_sync;

    localparam int CLK_HZ      = 1000;
    localparam int PPS_TIMEOUT = 2;
    localparam longint TO_CYC  = PPS_TIMEOUT * CLK_HZ;

    logic        clk = 1'b0;
    logic        reset;
    logic        pps_in;
    logic        set_valid;
    logic [31:0] set_seconds;
    logic        set_ready;
    logic [31:0] time_out;
    logic        time_valid;
    logic        tick_1hz;
    logic        pps_locked;

    int checks = 0;
    int fails  = 0;

    ntp_time_sync #(
        .CLK_HZ      (CLK_HZ),
        .PPS_TIMEOUT (PPS_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pps_in      (pps_in),
        .set_valid   (set_valid),
        .set_seconds (set_seconds),
        .set_ready   (set_ready),
        .time_out    (time_out),
        .time_valid  (time_valid),
        .tick_1hz    (tick_1hz),
        .pps_locked  (pps_locked)
    );

    always #5 clk = ~clk;

    // Reference model: time is tracked against absolute edge numbers
    // (second boundary, arming edge, last PPS edge) rather than counters.
    int          ms = 0;
    logic [31:0] mtime = 0, mpend = 0;
    bit          mvalid = 0, mtick = 0, mlocked = 0, have_pps = 0, mon = 0;
    bit          h1 = 0, h2 = 0, h3 = 0, rise, xfer;
    longint      c = 0, bnd = 0, arm_start = 0, last_pps = 0, ph;

    initial begin
        forever begin
            @(posedge clk);
            c++;
            if (reset) begin
                ms = 0; mpend = 0; mtime = 0; mvalid = 0; mtick = 0; mlocked = 0;
                have_pps = 0; h1 = 0; h2 = 0; h3 = 0; bnd = c; mon = 1;
            end else begin
                rise = h2 & ~h3;
                h3 = h2; h2 = h1; h1 = pps_in;
                xfer = set_valid && (ms != 1);
                mtick = 0;
                if (mvalid) begin
                    ph = c - bnd - 1;
                    if (rise) begin
                        if (ph >= CLK_HZ / 2) begin mtime++; mtick = 1; end
                        bnd = c; last_pps = c; have_pps = 1;
                    end else if (ph == CLK_HZ - 1) begin
                        mtime++; mtick = 1; bnd = c;
                    end
                end
                if (ms == 1 && (rise || (c - arm_start) == TO_CYC)) begin
                    mtime = mpend; bnd = c; mvalid = 1; mtick = 1; ms = 2;
                    have_pps = rise; last_pps = c;
                end else if (xfer) begin
                    ms = 1; arm_start = c; mpend = set_seconds;
                end
                mlocked = have_pps && ((c - last_pps) < TO_CYC);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon) begin
                chk("time_out",   time_out,          mtime);
                chk("time_valid", {31'd0, time_valid}, {31'd0, mvalid});
                chk("tick_1hz",   {31'd0, tick_1hz},   {31'd0, mtick});
                chk("pps_locked", {31'd0, pps_locked}, {31'd0, mlocked});
                chk("set_ready",  {31'd0, set_ready},  {31'd0, ms != 1});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
    endtask

    task automatic do_set(input logic [31:0] v, input int hold);
        set_valid   = 1'b1;
        set_seconds = v;
        step(hold);
        set_valid   = 1'b0;
    endtask

    task automatic pps_pulse(input int w);
        pps_in = 1'b1;
        step(w);
        pps_in = 1'b0;
    endtask

    logic [31:0] a_val, b_val;

    initial begin
        reset = 1'b1; pps_in = 1'b0; set_valid = 1'b0; set_seconds = '0;
        step(3);
        chk("reset_time", time_out, 32'd0);
        chk("reset_ready", {31'd0, set_ready}, 32'd1);
        reset = 1'b0;

        // First load on PPS: visible two edges after pps_in is sampled.
        do_set(32'h6000_0000, 1);
        step(5);
        pps_in = 1'b1;
        step(2);
        chk("s1_valid_before", {31'd0, time_valid}, 32'd0);
        step(1);
        pps_in = 1'b0;
        chk("s1_time", time_out, 32'h6000_0000);
        chk("s1_valid", {31'd0, time_valid}, 32'd1);
        chk("s1_locked", {31'd0, pps_locked}, 32'd1);
        chk("s1_tick", {31'd0, tick_1hz}, 32'd1);
        step(1);
        chk("s1_tick_one", {31'd0, tick_1hz}, 32'd0);
        step(200);

        // Arming timeout without PPS.
        do_reset(2);
        do_set(32'd5, 1);
        step(1999);
        chk("s2_not_yet", {31'd0, time_valid}, 32'd0);
        step(1);
        chk("s2_time", time_out, 32'd5);
        chk("s2_unlocked", {31'd0, pps_locked}, 32'd0);
        step(1000);
        chk("s2_time6", time_out, 32'd6);
        chk("s2_tick6", {31'd0, tick_1hz}, 32'd1);
        step(1000);
        chk("s2_time7", time_out, 32'd7);

        // Early PPS at subsec 990, then late PPS at subsec 10.
        do_reset(2);
        do_set(32'd100, 1);
        step(3);
        pps_pulse(3);
        chk("s3_load", time_out, 32'd100);
        step(988);
        pps_pulse(3);
        chk("s3_early", time_out, 32'd101);
        chk("s3_early_tick", {31'd0, tick_1hz}, 32'd1);
        step(999);
        chk("s3_no_double", time_out, 32'd101);
        step(1);
        chk("s3_roll", time_out, 32'd102);
        step(8);
        pps_pulse(3);
        chk("s3_late", time_out, 32'd102);
        chk("s3_late_tick", {31'd0, tick_1hz}, 32'd0);
        step(999);
        chk("s3_realigned", time_out, 32'd102);
        step(1);
        chk("s3_realigned_roll", time_out, 32'd103);

        // PPS stops: lock drops at the second unsupported rollover, then relocks.
        step(999);
        chk("s4_still_locked", {31'd0, pps_locked}, 32'd1);
        step(1);
        chk("s4_unlocked", {31'd0, pps_locked}, 32'd0);
        chk("s4_counting", time_out, 32'd104);
        step(100);
        pps_pulse(3);
        chk("s4_relock", {31'd0, pps_locked}, 32'd1);

        // Wrap from 0xFFFFFFFF.
        do_reset(2);
        do_set(32'hFFFF_FFFF, 1);
        step(3);
        pps_pulse(3);
        step(1000);
        chk("s5_wrap", time_out, 32'd0);
        chk("s5_wrap_tick", {31'd0, tick_1hz}, 32'd1);

        // set_valid held through ARMED, then transfer coinciding with pps_rise.
        do_reset(2);
        a_val = $urandom;
        set_valid = 1'b1; set_seconds = a_val;
        step(1);
        for (int i = 0; i < 20; i++) begin
            set_seconds = $urandom;
            step(1);
        end
        pps_pulse(3);
        set_valid = 1'b0;
        chk("s6_held_load", time_out, a_val);
        step(300);
        b_val = a_val ^ 32'h5A5A_0001;
        pps_in = 1'b1;
        step(2);
        set_valid = 1'b1; set_seconds = b_val;
        step(1);
        set_valid = 1'b0; pps_in = 1'b0;
        chk("s6_coincide_time", time_out, a_val);
        chk("s6_coincide_ready", {31'd0, set_ready}, 32'd0);
        step(10);
        pps_pulse(3);
        chk("s6_next_pps", time_out, b_val);

        // Reset while ARMED with time running.
        do_set($urandom, 1);
        step(50);
        reset = 1'b1;
        step(1);
        chk("s7_time", time_out, 32'd0);
        chk("s7_valid", {31'd0, time_valid}, 32'd0);
        chk("s7_locked", {31'd0, pps_locked}, 32'd0);
        chk("s7_ready", {31'd0, set_ready}, 32'd1);
        step(1);
        reset = 1'b0;
        step(2500);
        chk("s7_no_load", {31'd0, time_valid}, 32'd0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                step($urandom_range(400, 1100));
                pps_pulse($urandom_range(2, 4));
            end else if (r < 8) begin
                do_set(($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom), $urandom_range(1, 3));
                step($urandom_range(1, 50));
            end else if (r == 8) begin
                step($urandom_range(1, 2500));
            end else begin
                do_reset(2);
            end
        end
        step(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
